// File: rtl/dmem_ctrl.sv
// Data-memory responder: services EX loads/stores against a single-port
// synchronous RAM, doing read-modify-write for partial-word stores.
module dmem_ctrl #(
  parameter int W_WORD = 32,
  parameter int W_ADDR = 16,
  parameter int W_RD   = 5,
  parameter int W_BE   = W_WORD / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  output logic              stall_o,
  input  logic              we_i,
  input  logic [W_BE-1:0]   be_i,
  input  logic [W_ADDR-1:0] addr_i,
  input  logic [W_WORD-1:0] wdata_i,
  input  logic [W_RD-1:0]   rd_num_i,
  output logic              wb_o,
  output logic [W_RD-1:0]   rd_num_o,
  output logic [W_WORD-1:0] rd_data_o,
  output logic [W_ADDR-1:0] mem_a_o,
  output logic              mem_w_o,
  output logic [W_WORD-1:0] mem_d_o,
  input  logic [W_WORD-1:0] mem_q_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RMW  = 2'd2;

  logic [1:0]        state, state_nx;
  logic [W_ADDR-1:0] addr_q;
  logic [W_WORD-1:0] wdata_q;
  logic [W_BE-1:0]   be_q;
  logic [W_RD-1:0]   rd_q;
  logic              wb_q;
  logic [W_RD-1:0]   rd_num_q;
  logic [W_WORD-1:0] rd_data_q;
  logic [W_WORD-1:0] merged;
  logic              mem_w;
  logic              accept;
  logic              be_full;
  logic              be_none;

  assign accept  = v_i && (state == S_IDLE);
  assign be_full = &be_i;
  assign be_none = ~|be_i;

  // Outputs are held at their reset values for the whole time rst is high,
  // including the cycle before the reset edge takes effect.
  assign stall_o   = (state != S_IDLE) && !rst;
  assign wb_o      = wb_q && !rst;
  assign rd_num_o  = rst ? '0 : rd_num_q;
  assign rd_data_o = rst ? '0 : rd_data_q;
  assign mem_w_o   = mem_w && !rst;

  always_comb begin
    merged = mem_q_i;
    for (int unsigned k = 0; k < W_BE; k++) begin
      if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
    end
  end

  always_comb begin
    state_nx = state;
    mem_a_o  = addr_i;
    mem_w    = 1'b0;
    mem_d_o  = wdata_i;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!we_i)        state_nx = S_LOAD;
          else if (be_full) mem_w    = 1'b1;
          else if (!be_none) state_nx = S_RMW;
        end
      end
      S_LOAD: begin
        mem_a_o  = addr_q;
        state_nx = S_IDLE;
      end
      S_RMW: begin
        mem_a_o  = addr_q;
        mem_w    = 1'b1;
        mem_d_o  = merged;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      rd_num_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
        rd_q    <= rd_num_i;
      end
      wb_q <= (state == S_LOAD);
      if (state == S_LOAD) begin
        rd_num_q  <= rd_q;
        rd_data_q <= mem_q_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: behavioural RAM plus a transaction-level reference
// model (word array + writeback queue), directed and random request streams.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  rd = '0;
  logic        stall_o, wb_o, mem_w_o;
  logic [4:0]  rd_num_o;
  logic [31:0] rd_data_o, mem_d_o, mem_q;
  logic [15:0] mem_a_o;

  logic [31:0] ram     [0:65535];
  logic [31:0] ref_mem [0:65535];

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t wbq[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          exp_stall = 0;
  bit          last_acc = 0;
  bit          pend_valid = 0;
  logic [15:0] pend_addr;
  logic [31:0] pend_wdata;
  logic [3:0]  pend_be;
  logic [4:0]  exp_rd_num = '0;
  logic [31:0] exp_rd_data = '0;

  dmem_ctrl #(.W_WORD(32), .W_ADDR(16), .W_RD(5)) dut (
    .clk(clk), .rst(rst), .v_i(v), .stall_o(stall_o), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rd_num_i(rd), .wb_o(wb_o),
    .rd_num_o(rd_num_o), .rd_data_o(rd_data_o), .mem_a_o(mem_a_o),
    .mem_w_o(mem_w_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w_o) ram[mem_a_o] <= mem_d_o;
    mem_q <= ram[mem_a_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (mask[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  // One clock cycle: inputs are already set; check, advance the model, step.
  task automatic tick();
    bit          exp_w;
    logic [15:0] exp_a;
    logic [31:0] exp_d;
    #1;
    last_acc = 0;
    if (rst) begin
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_wb", 32'(wb_o), 32'd0);
      check("rst_rd_num", 32'(rd_num_o), 32'd0);
      check("rst_rd_data", rd_data_o, 32'd0);
      check("rst_mem_w", 32'(mem_w_o), 32'd0);
      wbq.delete();
      pend_valid  = 0;
      exp_stall   = 0;
      exp_rd_num  = '0;
      exp_rd_data = '0;
    end else begin
      check("stall", 32'(stall_o), 32'(exp_stall));
      if (wbq.size() > 0 && wbq[0].due == cyc) begin
        check("wb", 32'(wb_o), 32'd1);
        exp_rd_num  = wbq[0].rd;
        exp_rd_data = wbq[0].data;
        void'(wbq.pop_front());
      end else begin
        check("wb", 32'(wb_o), 32'd0);
      end
      check("rd_num", 32'(rd_num_o), 32'(exp_rd_num));
      check("rd_data", rd_data_o, exp_rd_data);

      exp_w = 0; exp_a = '0; exp_d = '0;
      if (pend_valid) begin
        exp_w = 1; exp_a = pend_addr;
        exp_d = merge(ref_mem[pend_addr], pend_wdata, pend_be);
        ref_mem[pend_addr] = exp_d;
        pend_valid = 0;
      end else if (v && !exp_stall && we && be == 4'hF) begin
        exp_w = 1; exp_a = addr; exp_d = wdata;
      end
      check("mem_w", 32'(mem_w_o), 32'(exp_w));
      if (exp_w) begin
        check("mem_a", 32'(mem_a_o), 32'(exp_a));
        check("mem_d", mem_d_o, exp_d);
      end

      last_acc  = v && !exp_stall;
      exp_stall = 0;
      if (last_acc) begin
        if (!we) begin
          wbq.push_back('{due: cyc + 2, rd: rd, data: ref_mem[addr]});
          exp_stall = 1;
        end else if (be == 4'hF) begin
          ref_mem[addr] = wdata;
        end else if (be != 4'h0) begin
          pend_valid = 1; pend_addr = addr; pend_wdata = wdata; pend_be = be;
          exp_stall = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req(input bit w, input logic [3:0] m, input logic [15:0] a,
                     input logic [31:0] d, input logic [4:0] r);
    v = 1; we = w; be = m; addr = a; wdata = d; rd = r;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: request at addr %h never accepted", a);
    end
    v = 0;
  endtask

  task automatic idle(input int n);
    v = 0;
    repeat (n) tick();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    @(posedge clk);
    #1;
    rst = 1;
    idle(3);
    rst = 0;
    idle(1);

    req(1, 4'hF, 16'h0010, 32'hDEADBEEF, 5'd0);
    idle(1);
    req(0, 4'h0, 16'h0010, 32'h0, 5'd3);
    idle(3);
    check("dir_load_data", rd_data_o, 32'hDEADBEEF);
    check("dir_load_rd", 32'(rd_num_o), 32'd3);

    req(1, 4'b0101, 16'h0010, 32'h11223344, 5'd0);
    req(0, 4'h0, 16'h0010, 32'h0, 5'd4);
    idle(3);
    check("dir_rmw_data", rd_data_o, 32'hDE22BE44);

    for (int i = 0; i < 4; i++) req(1, 4'hF, 16'(i), $urandom, 5'd0);
    req(0, 4'h0, 16'h0002, 32'h0, 5'd9);
    idle(3);
    check("dir_b2b_data", rd_data_o, ref_mem[2]);

    // be=0 store presented while the preceding load stalls
    req(0, 4'h0, 16'h0010, 32'h0, 5'd5);
    req(1, 4'h0, 16'h0010, 32'hCAFEF00D, 5'd0);
    req(0, 4'h0, 16'h0010, 32'h0, 5'd6);
    idle(3);
    check("dir_nop_data", rd_data_o, 32'hDE22BE44);

    req(1, 4'b0011, 16'h0010, 32'h55667788, 5'd0);
    rst = 1;
    tick();
    rst = 0;
    idle(2);
    req(0, 4'h0, 16'h0010, 32'h0, 5'd7);
    idle(3);
    check("dir_rst_rmw_data", rd_data_o, 32'hDE22BE44);

    req(0, 4'h0, 16'h0020, 32'h0, 5'd8);
    rst = 1;
    tick();
    rst = 0;
    idle(3);
    check("dir_rst_load_stall", 32'(stall_o), 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] m;
      case ($urandom_range(0, 3))
        0:       m = 4'h0;
        1:       m = 4'hF;
        default: m = 4'($urandom);
      endcase
      req(1'($urandom), m, 16'($urandom_range(0, 31)), $urandom, 5'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    check("final_wbq_empty", 32'(wbq.size()), 32'd0);

    for (int i = 0; i < 64; i++) check("ram_word", ram[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
